ahb_to_axi_hs_src: RTL and testbench
====================================

// Module: ahb_to_axi_hs_src
// PURPOSE
//  Source-side 4-phase req/ack handshake controller for single-word transfers into the AXI clock domain.
//  - Captures a data word on a start pulse and holds it stable on data_o.
//  - Drives req_o into the destination-domain 2-flop synchronizer.
//  - Completes the 4-phase cycle using ack_sync_i, which the peer synchronizer has already resynchronised into CLK.
//  Sits directly upstream of the AHB->AXI double synchronizer.
// PARAMETERS
//  DATA_W      32    width of the transferred word
//  TO_CYCLES   1024  cycles allowed per handshake phase before timeout (used only with the timeout macro; must be >=2)
// PORTS
//  CLK         in   1       source-domain clock
//  rst         in   1       asynchronous reset, active-high
//  start_i     in   1       single-cycle request to send data_i
//  data_i      in   DATA_W  word to transfer, sampled when start_i is accepted
//  busy_o      out  1       handshake in progress; start_i is not accepted
//  drop_o      out  1       1-cycle pulse: start_i was rejected
//  req_o       out  1       request level to the destination synchronizer
//  data_o      out  DATA_W  captured word, stable while req_o=1 and until the next accept
//  ack_sync_i  in   1       destination ack, already synchronised into CLK
//  done_o      out  1       1-cycle pulse: 4-phase cycle complete
//  err_o       out  1       1-cycle pulse: phase timeout (timeout build only)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE.
//  - req_o=0, busy_o=0, done_o=0, drop_o=0, err_o=0, data_o=0, phase counter=0.
//  All outputs are registered; there are no combinational paths from input to output.
//  States:
//  - IDLE
//    - start_i=1 and ack_sync_i=0: accept. data_o<=data_i, req_o<=1, busy_o<=1, go to REQ.
//    - start_i=1 and ack_sync_i=1 (stale ack): reject. drop_o pulses; stay in IDLE.
//  - REQ: hold req_o=1.
//    - ack_sync_i=1: req_o<=0, go to REL.
//  - REL: hold req_o=0.
//    - ack_sync_i=0: done_o<=1 for 1 cycle, busy_o<=0, go to IDLE.
//  Latency:
//  - start_i accepted at edge N: req_o=1 and busy_o=1 from N+1.
//  - ack_sync_i rises, sampled at edge K: req_o=0 from K+1.
//  - ack_sync_i falls, sampled at edge M: done_o=1 and busy_o=0 during M+1.
//  - A new start_i in cycle M+1 is accepted (back-to-back transfers allowed).
//  Rules:
//  - start_i while busy_o=1: ignored, drop_o pulses; data_o and state are unchanged.
//  - data_o changes only on accept; it holds its value in IDLE after done_o.
//  - ack_sync_i glitch-free assumption is the synchronizer's responsibility; no filtering here.
//  - ack_sync_i=1 and =0 levels are only acted on in REQ and REL respectively; in IDLE only the stale-ack check applies.
//  - rst mid-handshake: immediate return to IDLE, req_o=0, no done_o or err_o. The peer recovers on its own reset.
// CONFIGURATION
//  Macro AHBTOAXI_HS_TIMEOUT_EN.
//  - Defined:
//    - Phase counter clears on every state entry and increments each cycle in REQ or REL.
//    - Counter reaching TO_CYCLES-1 in REQ without ack: req_o<=0, err_o pulses, go to REL.
//    - Counter reaching TO_CYCLES-1 in REL without ack drop: err_o pulses, busy_o<=0, go to IDLE, no done_o.
//    - Counter width is $clog2(TO_CYCLES); the counter saturates and never wraps.
//  - Undefined:
//    - No counter; REQ and REL wait indefinitely.
//    - err_o is tied to 0; TO_CYCLES is unused.
// TESTING
//  1. Reset: assert rst mid-REQ -> req_o=0, busy_o=0, data_o=0 asynchronously; no done_o after release.
//  2. Nominal: start_i with data_i=32'hDEADBEEF at N, ack rises N+3, falls N+6.
//     -> req_o=1 during N+1..N+3; data_o=DEADBEEF; done_o during N+7 only.
//  3. Back-to-back: second start_i (data 32'h12345678) in the done_o cycle
//     -> accepted, req_o=1 next cycle, data_o=12345678.
//  4. Busy/stale: start_i during REQ -> drop_o 1 cycle, data_o unchanged;
//     start_i in IDLE with ack_sync_i=1 -> drop_o, req_o stays 0.
//  5. Timeout (macro on, TO_CYCLES=8): no ack for 8 cycles -> err_o pulse, req_o=0, then IDLE; no done_o.
//     Macro off -> req_o held high for 1000 cycles, err_o=0.

Source files
------------

// File: rtl/ahb_to_axi_hs_src.sv
// ---------------------------------------------------------------------------
// ahb_to_axi_hs_src
//
// Source-side 4-phase req/ack handshake controller. It moves one data word at
// a time from the AHB clock domain toward the AXI clock domain. It sits
// directly upstream of the AHB->AXI double synchronizer.
//
// Operation:
//   - A start_i pulse captures data_i into data_o and raises req_o.
//   - data_o is held stable while the destination side samples it.
//   - The returning ack (ack_sync_i, already resynchronised into CLK) first
//     rises. req_o then drops, and the cycle finishes when the ack falls.
//
// Optional feature: define AHBTOAXI_HS_TIMEOUT_EN to add a per-phase timeout.
// When the macro is undefined, REQ and REL wait forever and err_o is held at 0.
//
// Parameters:
//   DATA_W     width of the transferred word
//   TO_CYCLES  cycles allowed per handshake phase in the timeout build (>= 2)
//
// Ports:
//   CLK         in   source-domain clock
//   rst         in   asynchronous reset, active-high
//   start_i     in   single-cycle request to send data_i
//   data_i      in   word to transfer, sampled on accept
//   busy_o      out  handshake in progress; start_i is not accepted
//   drop_o      out  1-cycle pulse: start_i was rejected
//   req_o       out  request level to the destination synchronizer
//   data_o      out  captured word, stable until the next accept
//   ack_sync_i  in   destination ack, already synchronised into CLK
//   done_o      out  1-cycle pulse: 4-phase cycle complete
//   err_o       out  1-cycle pulse: phase timeout (timeout build only)
// ---------------------------------------------------------------------------
module ahb_to_axi_hs_src #(
  parameter int DATA_W    = 32,
  parameter int TO_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o,
  output logic              drop_o,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_sync_i,
  output logic              done_o,
  output logic              err_o
);

  // Catch an invalid timeout budget at elaboration time.
  if (TO_CYCLES < 2) begin : g_bad_to_cycles
    $error("ahb_to_axi_hs_src: TO_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_q, data_d;

`ifdef AHBTOAXI_HS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Marks that REQ was left by timeout. A REL reached this way ends with
  // err_o and never reports done_o, even though the ack is already low.
  logic             to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    busy_d  = busy_q;
    data_d  = data_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    err_d   = 1'b0;
`ifdef AHBTOAXI_HS_TIMEOUT_EN
    to_d    = to_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          // An ack still high from an earlier peer cycle would complete the
          // new handshake at once, so the request is refused instead.
          if (!ack_sync_i) begin
            data_d  = data_i;
            req_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = REQ;
          end else begin
            drop_d = 1'b1;
          end
        end
      end

      REQ: begin
        drop_d = start_i;
        if (ack_sync_i) begin
          req_d   = 1'b0;
          state_d = REL;
        end
`ifdef AHBTOAXI_HS_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = REL;
        end
`endif
      end

      REL: begin
        drop_d = start_i;
        if (!ack_sync_i) begin
`ifdef AHBTOAXI_HS_TIMEOUT_EN
          done_d = !to_q;
          to_d   = 1'b0;
`else
          done_d = 1'b1;
`endif
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef AHBTOAXI_HS_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          to_d    = 1'b0;
          state_d = IDLE;
        end
`endif
      end

      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef AHBTOAXI_HS_TIMEOUT_EN
  // The phase counter restarts on every state change. It saturates so that
  // it can never wrap back to a value below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != IDLE && cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
`endif

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign req_o  = req_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign drop_o = drop_q;
  assign data_o = data_q;
`ifdef AHBTOAXI_HS_TIMEOUT_EN
  assign err_o  = err_q;
`else
  // err_q is never set when the timeout is disabled, so err_o stays low.
  assign err_o  = 1'b0 & err_q;
`endif

endmodule

// File: tb/tb_ahb_to_axi_hs_src.sv
// ---------------------------------------------------------------------------
// tb_ahb_to_axi_hs_src
//
// Directed testbench for ahb_to_axi_hs_src. Inputs change on the falling
// edge, and outputs are checked just before the next input change, so every
// check sits half a period away from the rising edge.
// ---------------------------------------------------------------------------
module tb_ahb_to_axi_hs_src;

  localparam int DATA_W    = 32;
  localparam int TO_CYCLES = 8;

  logic              CLK = 1'b0;
  logic              rst;
  logic              start_i;
  logic [DATA_W-1:0] data_i;
  logic              ack_sync_i;
  logic              busy_o;
  logic              drop_o;
  logic              req_o;
  logic [DATA_W-1:0] data_o;
  logic              done_o;
  logic              err_o;

  int tests_run = 0;
  int tests_failed = 0;

  ahb_to_axi_hs_src #(
    .DATA_W    (DATA_W),
    .TO_CYCLES (TO_CYCLES)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .start_i    (start_i),
    .data_i     (data_i),
    .busy_o     (busy_o),
    .drop_o     (drop_o),
    .req_o      (req_o),
    .data_o     (data_o),
    .ack_sync_i (ack_sync_i),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 CLK = ~CLK;

  // Drive the inputs for the next rising edge.
  task automatic applyStimulus(input logic start, input logic [DATA_W-1:0] data,
                               input logic ack);
    start_i    = start;
    data_i     = data;
    ack_sync_i = ack;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge; the rising edge in between has been
  // applied to the outputs.
  task automatic nextCycle();
    @(negedge CLK);
  endtask

  initial begin
    int err_seen;
    int req_low_seen;

    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    repeat (2) nextCycle();

    // Reset state.
    checkOutput("reset_req",  {31'd0, req_o},  32'd0);
    checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset_data", data_o,          32'd0);
    checkOutput("reset_done", {31'd0, done_o}, 32'd0);
    checkOutput("reset_drop", {31'd0, drop_o}, 32'd0);
    checkOutput("reset_err",  {31'd0, err_o},  32'd0);
    rst = 1'b0;
    nextCycle();

    // Nominal handshake: start in cycle N, ack high from N+3, low from N+6.
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);                  // cycle N
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);                         // cycle N+1
    checkOutput("nom_req_n1",  {31'd0, req_o},  32'd1);
    checkOutput("nom_busy_n1", {31'd0, busy_o}, 32'd1);
    checkOutput("nom_data",    data_o,          32'hDEADBEEF);
    nextCycle();                                              // cycle N+2
    checkOutput("nom_req_n2", {31'd0, req_o}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);                         // cycle N+3
    checkOutput("nom_req_n3", {31'd0, req_o}, 32'd1);
    nextCycle();                                              // cycle N+4
    checkOutput("nom_req_n4",  {31'd0, req_o},  32'd0);
    checkOutput("nom_busy_n4", {31'd0, busy_o}, 32'd1);
    nextCycle();                                              // cycle N+5
    checkOutput("nom_done_n5", {31'd0, done_o}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);                         // cycle N+6
    checkOutput("nom_done_n6", {31'd0, done_o}, 32'd0);
    checkOutput("nom_busy_n6", {31'd0, busy_o}, 32'd1);
    nextCycle();                                              // cycle N+7
    checkOutput("nom_done_n7",  {31'd0, done_o}, 32'd1);
    checkOutput("nom_busy_n7",  {31'd0, busy_o}, 32'd0);
    checkOutput("nom_data_n7",  data_o,          32'hDEADBEEF);

    // Back-to-back: start in the done_o cycle is accepted.
    applyStimulus(1'b1, 32'h12345678, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("b2b_req",  {31'd0, req_o},  32'd1);
    checkOutput("b2b_data", data_o,          32'h12345678);
    checkOutput("b2b_done", {31'd0, done_o}, 32'd0);
    checkOutput("b2b_drop", {31'd0, drop_o}, 32'd0);

    // Busy: start during REQ is dropped and data_o is kept.
    applyStimulus(1'b1, 32'hAAAA5555, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("busy_drop", {31'd0, drop_o}, 32'd1);
    checkOutput("busy_data", data_o,          32'h12345678);
    checkOutput("busy_req",  {31'd0, req_o},  32'd1);
    nextCycle();
    checkOutput("busy_drop_end", {31'd0, drop_o}, 32'd0);

    // Finish that handshake.
    applyStimulus(1'b0, 32'h0, 1'b1);
    nextCycle();
    checkOutput("b2b_req_low", {31'd0, req_o}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    nextCycle();
    checkOutput("b2b_done_pulse", {31'd0, done_o}, 32'd1);

    // Stale ack in IDLE: start is refused.
    applyStimulus(1'b1, 32'h0BADF00D, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("stale_drop", {31'd0, drop_o}, 32'd1);
    checkOutput("stale_req",  {31'd0, req_o},  32'd0);
    checkOutput("stale_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("stale_data", data_o,          32'h12345678);
    nextCycle();

    // Reset in the middle of REQ acts immediately, without a clock edge.
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("rstmid_req_before", {31'd0, req_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstmid_req",  {31'd0, req_o},  32'd0);
    checkOutput("rstmid_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rstmid_data", data_o,          32'd0);
    nextCycle();
    rst = 1'b0;
    repeat (3) begin
      nextCycle();
      checkOutput("rstmid_no_done", {31'd0, done_o}, 32'd0);
      checkOutput("rstmid_no_err",  {31'd0, err_o},  32'd0);
    end

`ifdef AHBTOAXI_HS_TIMEOUT_EN
    // Timeout: REQ lasts 8 cycles without an ack, then err_o pulses and the
    // controller returns to IDLE without done_o.
    applyStimulus(1'b1, 32'h55AA55AA, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < TO_CYCLES; i++) begin
      checkOutput("to_req_held", {31'd0, req_o}, 32'd1);
      checkOutput("to_err_quiet", {31'd0, err_o}, 32'd0);
      nextCycle();
    end
    checkOutput("to_err",  {31'd0, err_o}, 32'd1);
    checkOutput("to_req0", {31'd0, req_o}, 32'd0);
    nextCycle();
    checkOutput("to_err_end", {31'd0, err_o},  32'd0);
    checkOutput("to_no_done", {31'd0, done_o}, 32'd0);
    checkOutput("to_idle",    {31'd0, busy_o}, 32'd0);
    nextCycle();
    checkOutput("to_no_done2", {31'd0, done_o}, 32'd0);
`else
    // No timeout: REQ holds for 1000 cycles and err_o never rises.
    applyStimulus(1'b1, 32'h55AA55AA, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    err_seen = 0;
    req_low_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      if (err_o !== 1'b0) err_seen++;
      if (req_o !== 1'b1) req_low_seen++;
      nextCycle();
    end
    checkOutput("noto_err_count",  err_seen,     32'd0);
    checkOutput("noto_req_drops",  req_low_seen, 32'd0);
    checkOutput("noto_busy",       {31'd0, busy_o}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    nextCycle();
    checkOutput("noto_req_low", {31'd0, req_o}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    nextCycle();
    checkOutput("noto_done", {31'd0, done_o}, 32'd1);
    checkOutput("noto_data", data_o,          32'h55AA55AA);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
